// File: rtl/pilha_pkg.sv
// Shared constants and the decoded-operation type for the pilha_lifo stack.
package pilha_pkg;

    localparam logic SRC_UC  = 1'b0;
    localparam logic SRC_ULA = 1'b1;

    localparam int PILHA_DATA_W = 16;
    localparam int PILHA_DEPTH  = 16;
    localparam int PILHA_ULA_W  = 32;

    typedef enum logic [1:0] {
        OP_IDLE,
        OP_PUSH,
        OP_POP,
        OP_REPLACE
    } pilha_op_e;

endpackage

// File: rtl/pilha_mem.sv
// DEPTH x DATA_W stack storage: synchronous write, asynchronous read. Contents are never reset.
module pilha_mem #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16,
    parameter int PTR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [PTR_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [PTR_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/pilha_lifo.sv
// Parametrised LIFO stack with push/pop/replace-top, registered pop output and error flags.
// Build option: define PILHA_STICKY_ERR_EN to make overflow/underflow sticky until rst or clear.
module pilha_lifo
    import pilha_pkg::*;
#(
    parameter int DATA_W = PILHA_DATA_W,
    parameter int DEPTH  = PILHA_DEPTH,
    parameter int ULA_W  = PILHA_ULA_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     clear,
    input  logic                     src_sel,
    input  logic [DATA_W-1:0]        din_uc,
    input  logic [ULA_W-1:0]         din_ula,
    output logic [DATA_W-1:0]        dout,
    output logic                     dout_valid,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0]   SP_FULL = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   SP_ONE  = 1;
    localparam logic [PTR_W-1:0] IDX_ONE = 1;

    logic [PTR_W:0]    sp;
    logic [PTR_W-1:0]  top_idx;
    logic [PTR_W-1:0]  mem_waddr;
    logic              mem_we;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] rd_data;
    pilha_op_e         op;

    generate
        if (ULA_W > DATA_W) begin : g_ula_hi
            // Upper ALU bits are dropped on purpose.
            logic unused_ula_hi;
            assign unused_ula_hi = ^din_ula[ULA_W-1:DATA_W];
        end
    endgenerate

    assign full    = (sp == SP_FULL);
    assign empty   = (sp == '0);
    assign count   = sp;
    assign top_idx = sp[PTR_W-1:0] - IDX_ONE;   // wraps to DEPTH-1 when sp == DEPTH

    always_comb begin
        wr_data = (src_sel == SRC_ULA) ? din_ula[DATA_W-1:0] : din_uc;
        op      = OP_IDLE;
        if (push && pop) begin
            op = OP_REPLACE;
        end else if (push) begin
            op = OP_PUSH;
        end else if (pop) begin
            op = OP_POP;
        end
    end

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = sp[PTR_W-1:0];
        if (!rst && !clear) begin
            if (op == OP_PUSH && !full) begin
                mem_we = 1'b1;
            end else if (op == OP_REPLACE && !empty) begin
                mem_we    = 1'b1;
                mem_waddr = top_idx;
            end
        end
    end

    pilha_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .PTR_W  (PTR_W)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (wr_data),
        .raddr (top_idx),
        .rdata (rd_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            sp         <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else if (clear) begin
            sp         <= '0;
            dout_valid <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            dout_valid <= 1'b0;
`ifndef PILHA_STICKY_ERR_EN
            overflow   <= 1'b0;
            underflow  <= 1'b0;
`endif
            case (op)
                OP_PUSH: begin
                    if (full) begin
                        overflow <= 1'b1;
                    end else begin
                        sp <= sp + SP_ONE;
                    end
                end
                OP_POP: begin
                    if (empty) begin
                        underflow <= 1'b1;
                    end else begin
                        dout       <= rd_data;
                        sp         <= sp - SP_ONE;
                        dout_valid <= 1'b1;
                    end
                end
                OP_REPLACE: begin
                    // Empty stack: the pushed word bypasses straight to dout.
                    dout       <= empty ? wr_data : rd_data;
                    dout_valid <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/pilha_lifo.md
Name: pilha_lifo

Overview:
Parametrised hardware LIFO stack for the processor datapath. It pushes either a control-unit (UC) word or a truncated ALU (ULA) result, and pops onto a registered output. It generalises the fixed 16x16 stack with configurable width and depth, explicit push/pop strobes, full/empty/count status, a simultaneous push+pop "replace top" mode, and overflow/underflow detection.

Parameters:
DATA_W, 16, stack word width
DEPTH, 16, number of entries (power of two, >=2)
ULA_W, 32, width of ALU input (>= DATA_W)
PTR_W, $clog2(DEPTH), index width (derived, localparam)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
push  in  1  push request, one word per cycle
pop  in  1  pop request, one word per cycle
clear  in  1  synchronous flush of stack contents
src_sel  in  1  push source: 0 = din_uc, 1 = din_ula
din_uc  in  DATA_W  UC data
din_ula  in  ULA_W  ALU data; low DATA_W bits used
dout  out  DATA_W  registered popped word
dout_valid  out  1  one-cycle pulse: dout updated this cycle
count  out  PTR_W+1  current occupancy, 0..DEPTH
full  out  1  count == DEPTH
empty  out  1  count == 0
overflow  out  1  push rejected (stack full)
underflow  out  1  pop rejected (stack empty)

Behaviour:
- Clock/reset: single clock clk; reset rst is synchronous, active-high.
- Reset: sp=0, dout=0, dout_valid=0, overflow=0, underflow=0. Memory contents are not reset and are don't-care.
- Priority, highest first: rst, clear, push/pop.
- clear: sp=0, dout_valid=0, error flags=0. dout holds its value. push/pop in the same cycle are ignored.
- Write data: din_uc when src_sel=0, else din_ula[DATA_W-1:0]. Upper ULA bits are discarded silently.
- Push only, not full: mem[sp] <= data; sp <= sp+1. dout is unchanged.
- Pop only, not empty: dout <= mem[sp-1]; sp <= sp-1; dout_valid=1 next cycle. Latency is 1 clock from pop to dout/dout_valid.
- Push+pop, not empty (replace top): dout <= old mem[sp-1]; mem[sp-1] <= data; sp unchanged; dout_valid=1.
- Push+pop, empty (bypass): dout <= data; sp stays 0; dout_valid=1; no underflow.
- Push+pop when full: treated as replace top; no overflow.
- Push only when full: ignored, sp unchanged, overflow=1 for one cycle.
- Pop only when empty: ignored, dout holds, dout_valid=0, underflow=1 for one cycle.
- Idle (no push, no pop): everything holds; dout_valid=0.
- count/full/empty are decoded from the sp register. They reflect state after the last edge, with no combinational path from push/pop.
- Pointer never wraps: sp is saturated by the full/empty guards.
- Reset mid-sequence: the stack is logically emptied and the next pop underflows.

Optional Feature:
Macro PILHA_STICKY_ERR_EN.
- Defined: overflow/underflow are sticky. They set on the error event and clear only on rst or clear.
- Undefined: overflow/underflow are one-cycle pulses as described above.
- Stack data behaviour is identical in both builds.

Decomposition:
- Package pilha_pkg: SRC_UC=1'b0, SRC_ULA=1'b1 constants; default DATA_W/DEPTH/ULA_W localparams; op enum {OP_IDLE, OP_PUSH, OP_POP, OP_REPLACE} used for the decoded action.
- Sub-module pilha_mem: DEPTH x DATA_W storage with synchronous write and asynchronous read port. The top level holds sp, the op decode, dout and the flags.

Test Plan:
- Reset, then push 0x1111, 0x2222, 0x3333 (src_sel=0), then pop x3 -> dout 0x3333, 0x2222, 0x1111, each with dout_valid one cycle after its pop; count 3 -> 0; empty=1 at end.
- src_sel=1, din_ula=0xDEAD_BEEF, push, pop -> dout=0xBEEF.
- Push DEPTH=16 words 0..15 -> full=1, count=16. A 17th push -> overflow pulse, count stays 16. Pop -> dout=15.
- Empty, pop -> underflow=1, dout_valid=0, dout unchanged. Then push+pop of 0x00AA -> dout=0x00AA, dout_valid=1, count=0.
- Push 0x0001, 0x0002; then push+pop with 0x0099 -> dout=0x0002, count=2. Next pop -> 0x0099.
- With 5 entries, assert clear (then rst) together with push -> count=0, push ignored. With PILHA_STICKY_ERR_EN, an underflow stays high until clear.
